// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the ALU arbiter slice.
package alu_arb_pkg;

    localparam int DW = 16;

    typedef enum logic [2:0] {
        OP_NEG    = 3'b000,
        OP_INC    = 3'b001,
        OP_ADDC   = 3'b010,
        OP_ADDSHR = 3'b011,
        OP_AND    = 3'b100,
        OP_OR     = 3'b101,
        OP_CAT    = 3'b110,
        OP_ZERO   = 3'b111
    } opc_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_arb_if.sv
// Request/response bundle between NREQ requesters and the shared ALU.
// master = requester/consumer side, slave = arbiter side.
interface alu_arb_if #(parameter int NREQ = 2);
    import alu_arb_pkg::*;

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ-1:0][DW-1:0] req_a;
    logic [NREQ-1:0][DW-1:0] req_b;
    logic [NREQ-1:0]         req_c;
    logic [NREQ-1:0][2:0]    req_opc;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [IDW-1:0]          rsp_id;
    logic [DW-1:0]           rsp_w;
    logic                    rsp_zer;
    logic                    rsp_neg;

    modport master (
        output req_valid, req_a, req_b, req_c, req_opc, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_w, rsp_zer, rsp_neg
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, req_opc, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_w, rsp_zer, rsp_neg
    );

endinterface

// File: rtl/alu_arbiter_datapath.sv
// Combinational 16-bit ALU; all arithmetic wraps, carries are dropped.
module alu_datapath
    import alu_arb_pkg::*;
(
    input  logic [DW-1:0] A,
    input  logic [DW-1:0] B,
    input  logic          c,
    input  opc_e          opc,
    output logic [DW-1:0] W,
    output logic          zer,
    output logic          neg
);

    // Opcode decode
    always_comb begin
        W = '0;
        case (opc)
            OP_NEG:    W = '0 - A;
            OP_INC:    W = A + 16'd1;
            OP_ADDC:   W = A + B + {{(DW-1){1'b0}}, c};
            OP_ADDSHR: W = A + (B >> 1);
            OP_AND:    W = A & B;
            OP_OR:     W = A | B;
            OP_CAT:    W = {A[7:0], B[7:0]};
            default:   W = '0;
        endcase
    end

    assign zer = (W == '0);
    assign neg = W[DW-1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter in front of one shared ALU: IDLE -> EXEC -> RESP.
// Optional feature macro: ALU_ARB_STATS_EN adds a saturating op_count output.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic          clk,
    input  logic          rst,
    alu_arb_if.slave      bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [DW-1:0] op_count
`endif
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e          state_q;
    logic [IDW-1:0]  last_q;
    logic [DW-1:0]   a_q, b_q;
    logic            c_q;
    opc_e            opc_q;
    logic            rsp_valid_q;
    logic [IDW-1:0]  rsp_id_q;
    logic [DW-1:0]   rsp_w_q;
    logic            rsp_zer_q, rsp_neg_q;

    logic            gnt_vld;
    logic [IDW-1:0]  gnt_idx;
    logic [IDW-1:0]  cand;
    logic [NREQ-1:0] ready_d;
    logic [DW-1:0]   alu_w;
    logic            alu_zer, alu_neg;

    // Round-robin pick: first valid requester after last_q, wrapping
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_q) + k) % NREQ);
            if (!gnt_vld && bus.req_valid[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    // Acceptance strobe is same-cycle, only while IDLE
    always_comb begin
        ready_d = '0;
        if (state_q == S_IDLE && gnt_vld)
            ready_d[gnt_idx] = 1'b1;
    end

    alu_datapath u_dp (
        .A   (a_q),
        .B   (b_q),
        .c   (c_q),
        .opc (opc_q),
        .W   (alu_w),
        .zer (alu_zer),
        .neg (alu_neg)
    );

    // Control FSM with registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            last_q      <= IDW'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            opc_q       <= OP_ZERO;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_w_q     <= '0;
            rsp_zer_q   <= 1'b0;
            rsp_neg_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld) begin
                        a_q     <= bus.req_a[gnt_idx];
                        b_q     <= bus.req_b[gnt_idx];
                        c_q     <= bus.req_c[gnt_idx];
                        opc_q   <= opc_e'(bus.req_opc[gnt_idx]);
                        last_q  <= gnt_idx;
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    rsp_w_q     <= alu_w;
                    rsp_zer_q   <= alu_zer;
                    rsp_neg_q   <= alu_neg;
                    rsp_id_q    <= last_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_d;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_w     = rsp_w_q;
    assign bus.rsp_zer   = rsp_zer_q;
    assign bus.rsp_neg   = rsp_neg_q;

`ifdef ALU_ARB_STATS_EN
    logic [DW-1:0] op_count_q;

    // Completed-response counter, sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst)
            op_count_q <= '0;
        else if (rsp_valid_q && bus.rsp_ready && op_count_q != '1)
            op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (NREQ=2): opcode table plus
// contention, backpressure, mid-operation reset and optional stats.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errs   = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_arb_if #(.NREQ(2)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [15:0] op_count;
    alu_arbiter #(.NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus), .op_count(op_count));
`else
    alu_arbiter #(.NREQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    typedef struct {
        int          id;
        logic [2:0]  opc;
        logic [15:0] a;
        logic [15:0] b;
        logic        c;
        logic [15:0] w;
        logic        zer;
        logic        neg;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        next_cyc();
        next_cyc();
        rst = 1'b0;
    endtask

    task automatic drive(input int id, input logic [2:0] opc, input logic [15:0] a,
                         input logic [15:0] b, input logic c);
        bus.req_opc[id] = opc;
        bus.req_a[id]   = a;
        bus.req_b[id]   = b;
        bus.req_c[id]   = c;
    endtask

    task automatic run_vec(input vec_t v);
        logic [1:0] oh;
        oh = 2'b00;
        oh[v.id] = 1'b1;
        drive(v.id, v.opc, v.a, v.b, v.c);
        bus.req_valid = oh;
        @(negedge clk);
        chk("accept_ready", 32'(bus.req_ready), 32'(oh));
        next_cyc();
        bus.req_valid = '0;
        @(negedge clk);
        chk("exec_no_valid", 32'(bus.rsp_valid), 32'd0);
        next_cyc();
        @(negedge clk);
        chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("rsp_w", 32'(bus.rsp_w), 32'(v.w));
        chk("rsp_zer", 32'(bus.rsp_zer), 32'(v.zer));
        chk("rsp_neg", 32'(bus.rsp_neg), 32'(v.neg));
        chk("rsp_id", 32'(bus.rsp_id), 32'(v.id));
        next_cyc();
        @(negedge clk);
        chk("resp_done", 32'(bus.rsp_valid), 32'd0);
        next_cyc();
    endtask

    initial begin
        int gnt[4];
        int gcyc[4];
        int ng;
        logic [15:0] held_w;

        //          id opc     a         b         c     w         z     n
        vecs[0]  = '{0, 3'b010, 16'h0005, 16'h0003, 1'b1, 16'h0009, 1'b0, 1'b0};
        vecs[1]  = '{0, 3'b000, 16'h0001, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b1};
        vecs[2]  = '{1, 3'b000, 16'h0000, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[3]  = '{0, 3'b001, 16'h7FFF, 16'h0000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4]  = '{1, 3'b001, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{0, 3'b010, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[6]  = '{1, 3'b011, 16'h0010, 16'h8001, 1'b0, 16'h4010, 1'b0, 1'b0};
        vecs[7]  = '{0, 3'b100, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, 1'b0};
        vecs[8]  = '{1, 3'b101, 16'hF000, 16'h000F, 1'b0, 16'hF00F, 1'b0, 1'b1};
        vecs[9]  = '{0, 3'b110, 16'h1234, 16'hABCD, 1'b0, 16'h34CD, 1'b0, 1'b0};
        vecs[10] = '{1, 3'b111, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{1, 3'b010, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0};

        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 2; i++) drive(i, 3'b111, 16'h0, 16'h0, 1'b0);
        do_reset();

        // reset state
        @(negedge clk);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_w", 32'(bus.rsp_w), 32'd0);
        chk("rst_rsp_zer", 32'(bus.rsp_zer), 32'd0);
        chk("rst_rsp_neg", 32'(bus.rsp_neg), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        next_cyc();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // contention: both requesters valid continuously -> 0,1,0,1 every 3 cycles
        do_reset();
        drive(0, 3'b001, 16'h0010, 16'h0, 1'b0);
        drive(1, 3'b001, 16'h0020, 16'h0, 1'b0);
        bus.req_valid = 2'b11;
        ng = 0;
        for (int cy = 0; cy < 30 && ng < 4; cy++) begin
            @(negedge clk);
            if (bus.req_ready != 2'b00) begin
                gnt[ng]  = (bus.req_ready == 2'b01) ? 0 : (bus.req_ready == 2'b10) ? 1 : 99;
                gcyc[ng] = cy;
                ng++;
            end
            next_cyc();
        end
        bus.req_valid = '0;
        chk("cont_grant_count", 32'(ng), 32'd4);
        for (int i = 0; i < ng; i++) begin
            chk("cont_grant_order", 32'(gnt[i]), 32'(i % 2));
            if (i > 0) chk("cont_grant_spacing", 32'(gcyc[i] - gcyc[i-1]), 32'd3);
        end
        repeat (3) next_cyc();

        // backpressure: response held 5 cycles, requester 1 waits
        do_reset();
        drive(0, 3'b010, 16'h0005, 16'h0003, 1'b1);
        drive(1, 3'b100, 16'h00FF, 16'h0F0F, 1'b0);
        bus.rsp_ready = 1'b0;
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("bp_accept", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = 2'b10;
        @(negedge clk);
        chk("bp_exec_ready", 32'(bus.req_ready), 32'h0);
        next_cyc();
        @(negedge clk);
        held_w = bus.rsp_w;
        chk("bp_first_w", 32'(held_w), 32'h0009);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_hold_w", 32'(bus.rsp_w), 32'h0009);
            chk("bp_hold_ready", 32'(bus.req_ready), 32'h0);
            next_cyc();
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(bus.rsp_valid), 32'd1);
        next_cyc();
        @(negedge clk);
        chk("bp_idle_valid", 32'(bus.rsp_valid), 32'd0);
        chk("bp_idle_grant1", 32'(bus.req_ready), 32'h2);
        next_cyc();
        bus.req_valid = '0;
        repeat (3) next_cyc();

        // reset during EXEC drops the op and restores requester-0 priority
        do_reset();
        drive(0, 3'b001, 16'h0001, 16'h0, 1'b0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        chk("mr_accept", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = 2'b00;
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        bus.req_valid = 2'b11;
        @(negedge clk);
        chk("mr_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mr_grant0", 32'(bus.req_ready), 32'h1);
        next_cyc();
        bus.req_valid = '0;
        repeat (3) next_cyc();

`ifdef ALU_ARB_STATS_EN
        do_reset();
        @(negedge clk);
        chk("stats_rst", 32'(op_count), 32'd0);
        next_cyc();
        for (int i = 0; i < 3; i++) run_vec(vecs[i]);
        @(negedge clk);
        chk("stats_three", 32'(op_count), 32'd3);
        next_cyc();
        do_reset();
        @(negedge clk);
        chk("stats_after_rst", 32'(op_count), 32'd0);
        next_cyc();
`endif

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    // Global time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1);
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters sharing the ALU (legal 2..4).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  NREQ  per-requester operation request.
REQ-005 req_ready  output  NREQ  one-hot acceptance strobe; handshake completes when valid and ready are both high.
REQ-006 req_a, req_b  input  NREQ x 16  signed operands per requester.
REQ-007 req_c  input  NREQ x 1  carry-in per requester.
REQ-008 req_opc  input  NREQ x 3  opcode per requester.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer accepts result.
REQ-011 rsp_id  output  clog2(NREQ)  index of requester owning the result.
REQ-012 rsp_w  output  16  result; rsp_zer, rsp_neg  output  1 each  zero and sign flags of rsp_w.

Function
REQ-013 The block SHALL sequence a 3-state FSM: IDLE, EXEC, RESP.
REQ-014 IDLE: if any req_valid is high, the block SHALL grant by round-robin starting at last_grant+1 (mod NREQ), assert req_ready only for the granted index in that same cycle, latch its A/B/c/opc, update last_grant, and go to EXEC; otherwise stay in IDLE with req_ready all zero.
REQ-015 req_ready SHALL be zero in EXEC and RESP; no operand is accepted outside IDLE.
REQ-016 EXEC: the block SHALL compute the latched operation, register rsp_w/rsp_zer/rsp_neg/rsp_id, and go to RESP.
REQ-017 RESP: rsp_valid SHALL be high and outputs stable until rsp_ready is high; on that cycle go to IDLE, rsp_valid low next cycle.
REQ-018 Latency: acceptance in cycle N SHALL give rsp_valid in cycle N+2; with rsp_ready held high, maximum throughput is one operation per 3 cycles.
REQ-019 Opcodes (16-bit, wrap-around, carries discarded): 000 -A; 001 A+1; 010 A+B+c; 011 A+(B logical-shift-right 1); 100 A AND B; 101 A OR B; 110 {A[7:0],B[7:0]}; 111 result 0.
REQ-020 rsp_zer SHALL be 1 iff rsp_w==0; rsp_neg SHALL equal rsp_w[15].
REQ-021 A requester deasserting req_valid while not granted SHALL lose nothing; a requester not yet granted keeps its round-robin position.

Reset
REQ-022 On rst the block SHALL enter IDLE regardless of state (including mid-EXEC/RESP, dropping the in-flight operation), with req_ready=0, rsp_valid=0, rsp_w=0, rsp_zer=0, rsp_neg=0, rsp_id=0, last_grant=NREQ-1 so requester 0 has first priority.

Configuration
REQ-023 With macro ALU_ARB_STATS_EN defined, the block SHALL add output op_count (16 bits), reset to 0, incremented on each rsp_valid&&rsp_ready, saturating at 16'hFFFF.
REQ-024 Without ALU_ARB_STATS_EN, op_count and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-025 A shared package SHALL hold the opcode enum (OP_NEG, OP_INC, OP_ADDC, OP_ADDSHR, OP_AND, OP_OR, OP_CAT, OP_ZERO), the FSM state typedef, and the data-width constant 16.
REQ-026 The combinational ALU SHALL be a separate sub-module alu_datapath (inputs A, B, c, opc; outputs W, zer, neg), instantiated once inside alu_arbiter.

Verification
REQ-027 Single request: req0 opc=010, A=16'h0005, B=16'h0003, c=1 -> req_ready[0] same cycle, rsp_valid 2 cycles later, rsp_w=16'h0009, rsp_id=0, zer=0, neg=0.
REQ-028 Negate: opc=000, A=16'h0001 -> rsp_w=16'hFFFF, neg=1; opc=000, A=0 -> rsp_w=0, zer=1.
REQ-029 Contention: req0 and req1 valid continuously after reset -> grants alternate 0,1,0,1 across four operations.
REQ-030 Backpressure: rsp_ready low 5 cycles in RESP -> rsp_valid and rsp_w stable, req_ready stays 0; release -> IDLE next cycle.
REQ-031 Reset mid-operation: rst asserted in EXEC -> next cycle rsp_valid=0, state IDLE, next grant goes to requester 0.
REQ-032 With ALU_ARB_STATS_EN: 3 completed responses -> op_count=3; after rst -> 0.
